// File: rtl/param_data_cache_pkg.sv
// Shared types and helpers for the set-associative write-back data cache.
// Line geometry, controller state encoding and byte-merge/tree-index helpers.
package param_data_cache_pkg;

    localparam int OFFSET_BITS = 5;
    localparam int LINE_BITS   = 256;
    localparam int WORD_BITS   = 32;

    typedef logic [LINE_BITS-1:0] line_t;
    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [31:0]          addr_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_FILL      = 2'd2
    } state_e;

    function automatic line_t merge_word(input line_t line, input logic [2:0] word_idx,
                                         input word_t wdata, input logic [3:0] mbe);
        line_t merged;
        merged = line;
        for (int b = 0; b < 4; b++) begin
            if (mbe[b]) begin
                merged[{word_idx, 5'b00000} + 8'(b * 8) +: 8] = wdata[b*8 +: 8];
            end
        end
        return merged;
    endfunction

    // Depth of a node in a heap-numbered tree (root = 1 sits at depth 0).
    function automatic int floor_log2(input int v);
        int r;
        r = 0;
        for (int i = 1; i < 31; i++) begin
            if (v >= (1 << i)) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/param_data_cache_plru.sv
// Tree pseudo-LRU state per set: heap-numbered node bits, 0 = victim on the left.
// Updated on a hit to point away from the hit way; victim way is combinational.
module param_data_cache_plru
    import param_data_cache_pkg::*;
#(
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [S_INDEX-1:0]          i_index,
    input  logic                        i_hit,
    input  logic [$clog2(NUM_WAYS)-1:0] i_hit_way,
    output logic [$clog2(NUM_WAYS)-1:0] o_victim
);
    localparam int SETS     = 1 << S_INDEX;
    localparam int LEVELS   = $clog2(NUM_WAYS);
    localparam int NODES    = NUM_WAYS - 1;
    localparam int WAY_BITS = $clog2(NUM_WAYS);

    logic [NODES-1:0] r_tree [SETS];
    logic [NODES-1:0] w_cur;
    logic [NODES-1:0] w_next;
    int               w_node;
    logic             w_dir;

    assign w_cur = r_tree[i_index];

    // Nodes on the hit way's path flip to point at the opposite subtree.
    always_comb begin
        w_next = w_cur;
        for (int n = 1; n <= NODES; n++) begin
            if ((int'(i_hit_way) >> (LEVELS - floor_log2(n))) == (n - (1 << floor_log2(n)))) begin
                w_next[n-1] = (((int'(i_hit_way) >> (LEVELS - 1 - floor_log2(n))) & 1) == 0);
            end else begin
                w_next[n-1] = w_cur[n-1];
            end
        end
    end

    // Walk from the root following the stored direction bits.
    always_comb begin
        w_node = 1;
        w_dir  = 1'b0;
        for (int l = 0; l < LEVELS; l++) begin
            w_dir = 1'b0;
            for (int n = 1; n <= NODES; n++) begin
                w_dir = (n == w_node) ? w_cur[n-1] : w_dir;
            end
            w_node = 2 * w_node + int'(w_dir);
        end
        o_victim = WAY_BITS'(w_node - NUM_WAYS);
    end

    // Tree bits, cleared on reset and touched only by hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_tree[s] <= '0;
            end
        end else if (i_hit) begin
            r_tree[i_index] <= w_next;
        end
    end

endmodule

// File: rtl/param_data_cache.sv
// Set-associative write-back / write-allocate data cache with registered CPU request,
// single-cycle hits and dirty-victim writeback followed by a full-line fill.
module param_data_cache
    import param_data_cache_pkg::*;
#(
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    output logic [31:0]  mem_rdata,
    input  logic [31:0]  mem_wdata,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_mbe,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    input  logic [255:0] pmem_rdata,
    output logic [255:0] pmem_wdata,
    output logic         pmem_read,
    output logic         pmem_write,
    input  logic         pmem_resp
);
    localparam int SETS     = 1 << S_INDEX;
    localparam int TAG_BITS = 32 - OFFSET_BITS - S_INDEX;
    localparam int WAY_BITS = $clog2(NUM_WAYS);

    addr_t               r_addr;
    word_t               r_wdata;
    logic                r_read;
    logic                r_write;
    logic [3:0]          r_mbe;
    logic [NUM_WAYS-1:0] r_valid [SETS];
    logic [NUM_WAYS-1:0] r_dirty [SETS];
    logic [TAG_BITS-1:0] r_tag   [SETS][NUM_WAYS];
    line_t               r_data  [SETS][NUM_WAYS];
    state_e              r_state;
    state_e              w_next_state;
    logic [WAY_BITS-1:0] r_victim;

    logic [S_INDEX-1:0]  w_index;
    logic [TAG_BITS-1:0] w_tag;
    logic [2:0]          w_word;
    logic                w_unused_addr;
    logic                w_hit;
    logic [WAY_BITS-1:0] w_hit_way;
    logic                w_has_inv;
    logic [WAY_BITS-1:0] w_inv_way;
    logic [WAY_BITS-1:0] w_plru_victim;
    logic [WAY_BITS-1:0] w_victim_way;
    logic                w_victim_dirty;
    line_t               w_hit_line;
    word_t               w_hit_word;
    logic                w_hit_upd;
    logic                w_wr_hit;
    logic                w_miss;
    logic                w_wb_done;
    logic                w_fill_done;

    assign w_index        = r_addr[OFFSET_BITS+S_INDEX-1:OFFSET_BITS];
    assign w_tag          = r_addr[31:OFFSET_BITS+S_INDEX];
    assign w_word         = r_addr[4:2];
    assign w_unused_addr  = ^r_addr[1:0];
    assign w_victim_way   = w_has_inv ? w_inv_way : w_plru_victim;
    assign w_victim_dirty = r_dirty[w_index][w_victim_way];
    assign w_hit_line     = r_data[w_index][w_hit_way];
    assign w_hit_word     = w_hit_line[{w_word, 5'b00000} +: 32];

    // Request input stage; every decision below works from these copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_mbe   <= '0;
        end else begin
            r_addr  <= mem_address;
            r_wdata <= mem_wdata;
            r_read  <= mem_read;
            r_write <= mem_write;
            r_mbe   <= mem_mbe;
        end
    end

    // Tag compare and lowest-index invalid way; descending scan lets way 0 win.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            w_hit     = (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) ? 1'b1 : w_hit;
            w_hit_way = (r_valid[w_index][w] && (r_tag[w_index][w] == w_tag)) ? WAY_BITS'(w) : w_hit_way;
            w_has_inv = (!r_valid[w_index][w]) ? 1'b1 : w_has_inv;
            w_inv_way = (!r_valid[w_index][w]) ? WAY_BITS'(w) : w_inv_way;
        end
    end

    param_data_cache_plru #(
        .S_INDEX  (S_INDEX),
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .clk       (clk),
        .rst       (rst),
        .i_index   (w_index),
        .i_hit     (w_hit_upd),
        .i_hit_way (w_hit_way),
        .o_victim  (w_plru_victim)
    );

    // Controller next state and all CPU/pmem outputs.
    always_comb begin
        w_next_state = r_state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        w_hit_upd    = 1'b0;
        w_wr_hit     = 1'b0;
        w_miss       = 1'b0;
        w_wb_done    = 1'b0;
        w_fill_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((r_read || r_write) && w_hit) begin
                    mem_resp     = 1'b1;
                    mem_rdata    = w_hit_word;
                    w_hit_upd    = 1'b1;
                    w_wr_hit     = r_write;
                    w_next_state = ST_IDLE;
                end else if (r_read || r_write) begin
                    w_miss       = 1'b1;
                    w_next_state = w_victim_dirty ? ST_WRITEBACK : ST_FILL;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[w_index][r_victim], w_index, 5'b00000};
                pmem_wdata   = r_data[w_index][r_victim];
                if (pmem_resp) begin
                    w_wb_done    = 1'b1;
                    w_next_state = ST_FILL;
                end else begin
                    w_next_state = ST_WRITEBACK;
                end
            end
            ST_FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {w_tag, w_index, 5'b00000};
                if (pmem_resp) begin
                    w_fill_done  = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_FILL;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Controller state and the victim way chosen when the miss was detected.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_victim <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_miss) begin
                r_victim <= w_victim_way;
            end
        end
    end

    // Valid and dirty bits; only these (and the tree) are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            if (w_wr_hit) begin
                r_dirty[w_index][w_hit_way] <= 1'b1;
            end
            if (w_wb_done) begin
                r_dirty[w_index][r_victim] <= 1'b0;
            end
            if (w_fill_done) begin
                r_valid[w_index][r_victim] <= 1'b1;
                r_dirty[w_index][r_victim] <= 1'b0;
            end
        end
    end

    // Line data and tags; contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (w_wr_hit) begin
            r_data[w_index][w_hit_way] <= merge_word(w_hit_line, w_word, r_wdata, r_mbe);
        end
        if (w_fill_done) begin
            r_data[w_index][r_victim] <= pmem_rdata;
            r_tag[w_index][r_victim]  <= w_tag;
        end
    end

endmodule

// File: tb/tb_param_data_cache.sv
// Directed bench for param_data_cache (S_INDEX=3, NUM_WAYS=2) with a small
// backing-memory responder; expected values are hand-derived from the fill pattern.
module tb_param_data_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic [31:0]  mem_rdata;
    logic [31:0]  mem_wdata;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_mbe;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_rdata;
    logic [255:0] pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic         pmem_resp;

    int           total = 0;
    int           bad   = 0;
    logic [255:0] mem_model [logic [31:0]];

    logic [31:0]  res_data;
    int           res_cycles;
    int           wb_cnt;
    int           rd_cnt;
    int           last_kind;
    logic [31:0]  wb_addr;
    logic [31:0]  rd_addr;
    logic [255:0] wb_data;
    logic         wb_first;
    logic         both_hi  = 1'b0;
    logic         drop_bad = 1'b0;
    logic [255:0] exp_line;
    logic         seen;

    always #5 clk = ~clk;

    param_data_cache #(
        .S_INDEX  (3),
        .NUM_WAYS (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (mem_address),
        .mem_rdata    (mem_rdata),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_mbe      (mem_mbe),
        .mem_resp     (mem_resp),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_wdata   (pmem_wdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_resp    (pmem_resp)
    );

    always @(posedge clk) begin
        if (mem_read && mem_write) begin
            $error("illegal request: mem_read and mem_write both high");
        end
    end

    function automatic logic [255:0] pat(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = {a[15:0], 8'h5A, 8'(w)};
        end
        return l;
    endfunction

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // One CPU request; answers pmem requests two cycles after they appear.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        int   wait_cnt;
        logic done;
        wait_cnt = 0; done = 1'b0; wb_cnt = 0; rd_cnt = 0; last_kind = 0;
        wb_addr = '0; rd_addr = '0; wb_data = '0; wb_first = 1'b0;
        res_data = '0; res_cycles = 0;
        @(negedge clk);
        mem_address = a; mem_wdata = d; mem_mbe = be; mem_read = rd; mem_write = wr;
        for (int n = 1; n <= 200 && !done; n++) begin
            @(negedge clk);
            if (pmem_resp) begin
                pmem_resp = 1'b0;
                wait_cnt  = 0;
                if ((last_kind == 1 && pmem_write) || (last_kind == 2 && pmem_read)) begin
                    drop_bad = 1'b1;
                end
            end
            if (pmem_read && pmem_write) begin
                both_hi = 1'b1;
            end
            if (mem_resp) begin
                res_data   = mem_rdata;
                res_cycles = n;
                done       = 1'b1;
                mem_read   = 1'b0;
                mem_write  = 1'b0;
            end else if (pmem_read || pmem_write) begin
                wait_cnt++;
                if (wait_cnt == 2) begin
                    pmem_resp = 1'b1;
                    if (pmem_write) begin
                        last_kind = 1;
                        wb_cnt++;
                        wb_addr  = pmem_address;
                        wb_data  = pmem_wdata;
                        wb_first = (rd_cnt == 0);
                        mem_model[pmem_address] = pmem_wdata;
                    end else begin
                        last_kind = 2;
                        rd_cnt++;
                        rd_addr    = pmem_address;
                        pmem_rdata = mem_model.exists(pmem_address) ? mem_model[pmem_address]
                                                                    : pat(pmem_address);
                    end
                end
            end
        end
        check_eq("resp_within_budget", done, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; mem_address = '0; mem_wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_mbe = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_ctrl", {mem_resp, pmem_read, pmem_write, pmem_address, mem_rdata}, '0);
        check_eq("reset_wdata", pmem_wdata, '0);

        // Cold read: clean fill of 0x1000, response the cycle after the fill response.
        access(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
        check_eq("cold_rd_cnt", rd_cnt, 1);
        check_eq("cold_rd_addr", rd_addr, 32'h0000_1000);
        check_eq("cold_wb_cnt", wb_cnt, 0);
        check_eq("cold_data", res_data, 32'h1000_5A01);
        check_eq("cold_latency", res_cycles, 4);

        access(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
        check_eq("rehit_latency", res_cycles, 1);
        check_eq("rehit_traffic", rd_cnt + wb_cnt, 0);
        check_eq("rehit_data", res_data, 32'h1000_5A01);

        access(1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b0011);
        check_eq("wr_hit_latency", res_cycles, 1);
        check_eq("wr_hit_traffic", rd_cnt + wb_cnt, 0);
        access(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
        check_eq("wr_merge_data", res_data, 32'h1000_BEEF);

        access(1'b1, 1'b0, 32'h0000_2008, 32'h0, 4'h0);
        check_eq("fill2_rd_addr", rd_addr, 32'h0000_2000);
        check_eq("fill2_wb_cnt", wb_cnt, 0);
        check_eq("fill2_data", res_data, 32'h2000_5A02);

        // Back-to-back hits: 0x2004 then 0x1000, leaving 0x2000 as the LRU way.
        @(negedge clk);
        mem_address = 32'h0000_2004; mem_read = 1'b1;
        @(negedge clk);
        check_eq("b2b_resp0", mem_resp, 1'b1);
        check_eq("b2b_data0", mem_rdata, 32'h2000_5A01);
        mem_address = 32'h0000_1000;
        @(negedge clk);
        check_eq("b2b_resp1", mem_resp, 1'b1);
        check_eq("b2b_data1", mem_rdata, 32'h1000_5A00);
        mem_read = 1'b0;

        access(1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
        check_eq("plru_rd_addr", rd_addr, 32'h0000_3000);
        check_eq("plru_wb_cnt", wb_cnt, 0);
        check_eq("plru_data", res_data, 32'h3000_5A00);
        check_eq("plru_latency", res_cycles, 4);

        // Now 0x1000 (dirty) is the PLRU victim: writeback precedes the fill.
        exp_line = pat(32'h0000_1000);
        exp_line[63:32] = 32'h1000_BEEF;
        access(1'b1, 1'b0, 32'h0000_200C, 32'h0, 4'h0);
        check_eq("dirty_wb_cnt", wb_cnt, 1);
        check_eq("dirty_wb_addr", wb_addr, 32'h0000_1000);
        check_eq("dirty_wb_data", wb_data, exp_line);
        check_eq("dirty_wb_first", wb_first, 1'b1);
        check_eq("dirty_rd_addr", rd_addr, 32'h0000_2000);
        check_eq("dirty_data", res_data, 32'h2000_5A03);
        check_eq("dirty_latency", res_cycles, 6);

        // Reset while a fill is outstanding.
        @(negedge clk);
        mem_address = 32'h0000_1004; mem_read = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (pmem_read) begin
                seen = 1'b1;
            end
        end
        check_eq("rst_fill_reached", seen, 1'b1);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        check_eq("rst_drop", {pmem_read, pmem_write, mem_resp}, 3'b000);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_resp || pmem_read || pmem_write) begin
                seen = 1'b1;
            end
        end
        check_eq("rst_quiet", seen, 1'b0);

        access(1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
        check_eq("post_rst_rd_cnt", rd_cnt, 1);
        check_eq("post_rst_rd_addr", rd_addr, 32'h0000_1000);
        check_eq("post_rst_data", res_data, 32'h1000_BEEF);
        check_eq("post_rst_latency", res_cycles, 4);

        check_eq("never_both_pmem", both_hi, 1'b0);
        check_eq("pmem_drop_after_resp", drop_bad, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
